regfile_2r1w: RTL
=================

# regfile_2r1w

Parametrised register file for the datapath: one synchronous write port, two independent combinational read ports, and a built-in clear sequencer that zeroes every register one per cycle after reset or on request. It is the next-generation datapath register file, feeding both ALU operands in the same cycle, with a `busy` flag that the controller FSM must respect before issuing register writes.

## Interface
Parameters:
- `DATA_W`, 16: register width in bits.
- `ADDR_W`, 3: register index width. `NREG = 2**ADDR_W` registers.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high. Starts a full clear.
- `data_in`, input, DATA_W: write data.
- `writenum`, input, ADDR_W: write index.
- `write`, input, 1: write enable.
- `readnum_a`, input, ADDR_W: read index, port A.
- `readnum_b`, input, ADDR_W: read index, port B.
- `clear`, input, 1: request a full clear while idle.
- `data_out_a`, output, DATA_W: port A read data.
- `data_out_b`, output, DATA_W: port B read data.
- `busy`, output, 1: high while the clear sequence runs.
- `write_dropped`, output, 1: one-cycle pulse flagging a write rejected while busy.

## Operation
- FSM with two states.
  - IDLE: normal operation.
  - CLEAR: zeroing registers using counter `cnt` (ADDR_W bits).
- Reset, at an edge with `reset=1`:
  - `state<=CLEAR`, `cnt<=0`, `write_dropped<=0`.
  - Register contents are not directly altered. Holding `reset` keeps the block at CLEAR with `cnt=0`.
- CLEAR, at each edge with `reset=0`:
  - `reg[cnt]<=0` and `cnt<=cnt+1`.
  - If `cnt==NREG-1`, then `state<=IDLE` and `cnt` wraps to 0.
- IDLE, at each edge:
  - If `write=1`: `reg[writenum]<=data_in`.
  - If `clear=1`: `state<=CLEAR`, `cnt<=0`.
  - A write and a clear in the same cycle: the write is performed, and the clear later zeroes it.
- `write=1` while in CLEAR: the write is ignored and `write_dropped<=1` for the following cycle only. Otherwise `write_dropped<=0`.
- `clear=1` while in CLEAR: ignored, and the sequence continues without restarting.
- `reset` during CLEAR: the sequence restarts at `cnt=0`.
- `busy = (state==CLEAR)`, decoded combinationally from state.
- Reads: `data_out_x = busy ? 0 : reg[readnum_x]`, combinational.
  - Both ports may address the same register or different registers.
  - Both may equal `writenum`.

## Timing
- Reset values: `busy=1`, `data_out_a=0`, `data_out_b=0`, `write_dropped=0`.
- Register contents are undefined until the first clear completes. Reads are masked to 0 during that time.
- Clear duration: exactly NREG edges with `reset=0`, 8 for the defaults. `busy` falls after the edge that clears `reg[NREG-1]`.
- Write latency: data written at edge N is visible on the read ports after edge N, without bypass.
- `write_dropped` rises one edge after the rejected write and lasts exactly one cycle per rejected cycle. Back-to-back rejected writes hold it high.
- No wrap issues on indices: all ADDR_W codes are valid registers.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When `write=1`, `busy=0`, and `writenum==readnum_x`, `data_out_x=data_in` in the same cycle (write-through, zero latency).
  - Applies independently to each port.
- Undefined: a read port shows the old register value until the write edge.
- `busy` masking takes priority over bypass in both builds.

## Test plan
(DATA_W=16, ADDR_W=3)
- Reset held 2 cycles, then released → `busy=1` for exactly 8 further cycles, and both outputs 0 throughout. After that, every register reads 0 on both ports.
- After the clear, write R0..R7 with `16'h0001<<i`, then read A=i and B=7-i for all i → A=`1<<i`, B=`1<<(7-i)`.
- `write=1`, `writenum=4`, `data_in=16'h0018`, `readnum_a=4`, `readnum_b=4`:
  - Without `REGFILE_BYPASS_EN`: old value before the edge, `16'h0018` after.
  - With it: `16'h0018` in the same cycle on both ports.
- `clear` pulsed in IDLE with `write` to R2=`16'h00FF` in the same cycle → `busy` for 8 cycles, then R2 reads 0.
- `write` R3=`16'hABCD` on cycle 3 of CLEAR → `write_dropped=1` for the next cycle only; after `busy` falls, R3 reads 0.
- `reset` asserted at clear cycle 5 → `cnt` restarts, and `busy` stays high for 8 cycles after `reset` deasserts.

Source files
------------

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with built-in clear sequencer
//
// Purpose: NREG = 2**ADDR_W registers of DATA_W bits. It has one synchronous
// write port and two combinational read ports. A sequencer zeroes one register
// per cycle after reset or on a clear request.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through to read ports).
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high, starts a full clear
//   data_in        in   write data
//   writenum       in   write index
//   write          in   write enable (ignored while busy)
//   readnum_a/b    in   read indices, ports A/B
//   clear          in   request a full clear while idle
//   data_out_a/b   out  read data, forced to 0 while busy
//   busy           out  clear sequence in progress
//   write_dropped  out  one-cycle pulse after a write rejected while busy
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy,
  output logic              write_dropped
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NREG - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wd_q, wd_d;
  logic [DATA_W-1:0] regs_q [NREG];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // Natural ADDR_W-bit wrap returns cnt to 0 on the last register.
        cnt_d = cnt_q + ADDR_W'(1);
        wd_d  = write;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy          = (state_q == S_CLEAR);
    write_dropped = wd_q;
  end

  // Register storage has no reset: contents become defined only once the
  // clear sequence has swept every entry. Reads are masked until then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        regs_q[cnt_q] <= '0;
      end else if (write) begin
        regs_q[writenum] <= data_in;
      end
    end
  end

  // Read ports: the busy mask overrides everything, including the bypass.
  always_comb begin
    data_out_a = regs_q[readnum_a];
    data_out_b = regs_q[readnum_b];
`ifdef REGFILE_BYPASS_EN
    if (write && (writenum == readnum_a)) data_out_a = data_in;
    if (write && (writenum == readnum_b)) data_out_b = data_in;
`else
`endif
    if (busy) begin
      data_out_a = '0;
      data_out_b = '0;
    end
  end

endmodule
